// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Trigger/capture sequencer for the four ADC readout streams (aclk domain).
//   Arms on request, accepts a software or external trigger, waits a
//   programmable delay, then opens a capture window of programmable length.
//
//   Ports
//     aclk, aresetn     clock, asynchronous active-low reset
//     arm_i, abort_i    one-cycle control pulses
//     trig_mask_i       bit0 = software trigger enable, bit1 = external
//     sw_trig_i         software trigger pulse
//     ext_trig_i        external trigger level (synchronous); rising edge used
//     trig_delay_i      delay D in cycles from trigger to window
//     cap_len_i         window length minus one
//     buf_tready_i      readout buffer ready, monitored during capture
//     cap_en_o          capture window
//     int_trig_o        one-cycle pulse on trigger acceptance
//     busy_o, done_o    status (ARMED/DELAY/CAPTURE, DONE)
//     overflow_o        sticky backpressure-during-capture flag
//     trig_count_o      accepted trigger count (wraps)
//     trig_time_o       timestamp of the last accepted trigger
//
//   Control inputs pass through one register stage before the state machine
//   acts on them, so every control-to-output path is two edges long.
module capture_sequencer #(
    parameter int LEN_BITS = 12,
    parameter int CNT_BITS = 16,
    parameter int TS_BITS  = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                arm_i,
    input  logic                abort_i,
    input  logic [1:0]          trig_mask_i,
    input  logic                sw_trig_i,
    input  logic                ext_trig_i,
    input  logic [LEN_BITS-1:0] trig_delay_i,
    input  logic [LEN_BITS-1:0] cap_len_i,
    input  logic [3:0]          buf_tready_i,
    output logic                cap_en_o,
    output logic                int_trig_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                overflow_o,
    output logic [CNT_BITS-1:0] trig_count_o,
    output logic [TS_BITS-1:0]  trig_time_o
);

    typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, DONE} state_t;

    state_t              state;
    logic [LEN_BITS-1:0] cnt;
    logic [LEN_BITS-1:0] delay_cfg;
    logic [LEN_BITS-1:0] len_cfg;
    logic [1:0]          mask_cfg;
    logic                arm_q;
    logic                abort_q;
    logic                sw_q;
    logic                rise_q;
    logic                ext_q;
    logic [TS_BITS-1:0]  ts;
    logic                trig;

    // Input stage. Arm and trigger are qualified against the state seen when
    // they are sampled, so a trigger in the arm cycle (state still IDLE) and
    // an arm during a running sequence are dropped here.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ext_q     <= 1'b0;
            abort_q   <= 1'b0;
            arm_q     <= 1'b0;
            sw_q      <= 1'b0;
            rise_q    <= 1'b0;
            delay_cfg <= '0;
            len_cfg   <= '0;
            mask_cfg  <= '0;
            ts        <= '0;
        end else begin
            ext_q   <= ext_trig_i;
            abort_q <= abort_i;
            arm_q   <= arm_i && (state == IDLE || state == DONE);
            sw_q    <= sw_trig_i && (state == ARMED);
            rise_q  <= ext_trig_i && !ext_q && (state == ARMED);
            ts      <= ts + TS_BITS'(1);
            // Config only loads on an acceptable arm and cannot change again
            // until the sequence returns to IDLE/DONE.
            if (arm_i && (state == IDLE || state == DONE)) begin
                delay_cfg <= trig_delay_i;
                len_cfg   <= cap_len_i;
                mask_cfg  <= trig_mask_i;
            end
        end
    end

    assign trig = (sw_q && mask_cfg[0]) || (rise_q && mask_cfg[1]);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            cnt          <= '0;
            cap_en_o     <= 1'b0;
            int_trig_o   <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            overflow_o   <= 1'b0;
            trig_count_o <= '0;
            trig_time_o  <= '0;
        end else begin
            int_trig_o <= 1'b0;
            if (cap_en_o && !(&buf_tready_i))
                overflow_o <= 1'b1;

            if (abort_q) begin
                state    <= IDLE;
                cap_en_o <= 1'b0;
                busy_o   <= 1'b0;
                done_o   <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (arm_q) begin
                            state      <= ARMED;
                            busy_o     <= 1'b1;
                            done_o     <= 1'b0;
                            overflow_o <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (trig) begin
                            int_trig_o   <= 1'b1;
                            trig_count_o <= trig_count_o + CNT_BITS'(1);
                            // Trigger was sampled one edge ago, so the counter
                            // value at that edge is the current value minus one.
                            trig_time_o  <= ts - TS_BITS'(1);
                            if (delay_cfg == '0) begin
                                state    <= CAPTURE;
                                cap_en_o <= 1'b1;
                                cnt      <= len_cfg;
                            end else begin
                                state <= DELAY;
                                cnt   <= delay_cfg - LEN_BITS'(1);
                            end
                        end
                    end
                    DELAY: begin
                        if (cnt == '0) begin
                            state    <= CAPTURE;
                            cap_en_o <= 1'b1;
                            cnt      <= len_cfg;
                        end else begin
                            cnt <= cnt - LEN_BITS'(1);
                        end
                    end
                    CAPTURE: begin
                        if (cnt == '0) begin
                            state    <= DONE;
                            cap_en_o <= 1'b0;
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                        end else begin
                            cnt <= cnt - LEN_BITS'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: a per-cycle vector table for the main
// sequences plus hand-written sequences for abort, masking, reset and wrap.
// The trigger counter is narrowed to 4 bits so the wrap case stays short.
module tb_capture_sequencer;
    localparam int LB = 12;
    localparam int CB = 4;
    localparam int TW = 32;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          arm_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [1:0]    trig_mask_i = 2'b00;
    logic          sw_trig_i = 1'b0;
    logic          ext_trig_i = 1'b0;
    logic [LB-1:0] trig_delay_i = '0;
    logic [LB-1:0] cap_len_i = '0;
    logic [3:0]    buf_tready_i = 4'hF;
    logic          cap_en_o, int_trig_o, busy_o, done_o, overflow_o;
    logic [CB-1:0] trig_count_o;
    logic [TW-1:0] trig_time_o;

    capture_sequencer #(.LEN_BITS(LB), .CNT_BITS(CB), .TS_BITS(TW)) dut (
        .aclk(aclk), .aresetn(aresetn), .arm_i(arm_i), .abort_i(abort_i),
        .trig_mask_i(trig_mask_i), .sw_trig_i(sw_trig_i), .ext_trig_i(ext_trig_i),
        .trig_delay_i(trig_delay_i), .cap_len_i(cap_len_i), .buf_tready_i(buf_tready_i),
        .cap_en_o(cap_en_o), .int_trig_o(int_trig_o), .busy_o(busy_o), .done_o(done_o),
        .overflow_o(overflow_o), .trig_count_o(trig_count_o), .trig_time_o(trig_time_o)
    );

    always #5 aclk = ~aclk;

    // Reference cycle counter: zero in reset, +1 per edge.
    logic [TW-1:0] ts_model;
    always @(posedge aclk or negedge aresetn)
        if (!aresetn) ts_model <= '0;
        else          ts_model <= ts_model + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic arm, abort, sw, ext;
        logic [1:0] mask;
        logic [LB-1:0] dly, len;
        logic [3:0] rdy;
        logic cap, itr, busy, done, ovf;
        logic [CB-1:0] cnt;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic arm, abort, sw, ext, input logic [1:0] mask,
                       input int dly, len, input logic [3:0] rdy,
                       input logic cap, itr, busy, done, ovf, input int cnt);
        vec_t v;
        v.arm = arm; v.abort = abort; v.sw = sw; v.ext = ext; v.mask = mask;
        v.dly = LB'(dly); v.len = LB'(len); v.rdy = rdy;
        v.cap = cap; v.itr = itr; v.busy = busy; v.done = done; v.ovf = ovf;
        v.cnt = CB'(cnt);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic run(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            tick();
            if (int_trig_o) pulses++;
        end
    endtask

    task automatic pulse_arm(input logic [1:0] m, input int d, input int l);
        arm_i = 1'b1; trig_mask_i = m; trig_delay_i = LB'(d); cap_len_i = LB'(l);
        tick();
        arm_i = 1'b0;
    endtask

    task automatic pulse_sw();
        sw_trig_i = 1'b1;
        tick();
        sw_trig_i = 1'b0;
    endtask

    initial begin
        int p;
        logic [TW-1:0] t_exp;

        // ---- vector table ----
        // Row = inputs driven before an edge, outputs expected after it.
        // Software trigger, D=0, len field 7 (8 beats), mask 01.
        add(1,0,0,0,2'b01,0,7,4'hF, 0,0,0,0,0,0);
        add(0,0,0,0,2'b01,0,7,4'hF, 0,0,1,0,0,0);
        add(0,0,1,0,2'b01,0,7,4'hF, 0,0,1,0,0,0);
        add(0,0,0,0,2'b01,0,7,4'hF, 1,1,1,0,0,1);
        for (int i = 0; i < 7; i++) add(0,0,0,0,2'b01,0,7,4'hF, 1,0,1,0,0,1);
        add(0,0,0,0,2'b01,0,7,4'hF, 0,0,0,1,0,1);
        // External trigger, D=5, len field 0, mask 10, ext held high 20 cycles.
        add(1,0,0,0,2'b10,5,0,4'hF, 0,0,0,1,0,1);
        add(0,0,0,0,2'b10,5,0,4'hF, 0,0,1,0,0,1);
        add(0,0,0,1,2'b10,5,0,4'hF, 0,0,1,0,0,1);
        add(0,0,0,1,2'b10,5,0,4'hF, 0,1,1,0,0,2);
        for (int i = 0; i < 4; i++) add(0,0,0,1,2'b10,5,0,4'hF, 0,0,1,0,0,2);
        add(0,0,0,1,2'b10,5,0,4'hF, 1,0,1,0,0,2);
        for (int i = 0; i < 13; i++) add(0,0,0,1,2'b10,5,0,4'hF, 0,0,0,1,0,2);
        add(0,0,0,0,2'b10,5,0,4'hF, 0,0,0,1,0,2);
        // Backpressure: glitch outside window ignored, glitch mid-capture sticks
        // through DONE, cleared by the next accepted arm; then abort.
        add(1,0,0,0,2'b01,2,5,4'b1011, 0,0,0,1,0,2);
        add(0,0,0,0,2'b01,2,5,4'hF, 0,0,1,0,0,2);
        add(0,0,1,0,2'b01,2,5,4'hF, 0,0,1,0,0,2);
        add(0,0,0,0,2'b01,2,5,4'hF, 0,1,1,0,0,3);
        add(0,0,0,0,2'b01,2,5,4'hF, 0,0,1,0,0,3);
        add(0,0,0,0,2'b01,2,5,4'hF, 1,0,1,0,0,3);
        add(0,0,0,0,2'b01,2,5,4'b1011, 1,0,1,0,1,3);
        for (int i = 0; i < 4; i++) add(0,0,0,0,2'b01,2,5,4'hF, 1,0,1,0,1,3);
        add(0,0,0,0,2'b01,2,5,4'hF, 0,0,0,1,1,3);
        add(0,0,0,0,2'b01,2,5,4'hF, 0,0,0,1,1,3);
        add(1,0,0,0,2'b01,0,0,4'hF, 0,0,0,1,1,3);
        add(0,0,0,0,2'b01,0,0,4'hF, 0,0,1,0,0,3);
        add(0,1,0,0,2'b01,0,0,4'hF, 0,0,1,0,0,3);
        add(0,0,0,0,2'b01,0,0,4'hF, 0,0,0,0,0,3);

        // ---- reset state ----
        repeat (2) @(posedge aclk);
        #1;
        chk("rst.cap", cap_en_o, 0);  chk("rst.busy", busy_o, 0);
        chk("rst.done", done_o, 0);   chk("rst.int", int_trig_o, 0);
        chk("rst.ovf", overflow_o, 0); chk("rst.cnt", trig_count_o, 0);
        chk("rst.time", trig_time_o, 0);
        aresetn = 1'b1;

        foreach (vecs[i]) begin
            arm_i = vecs[i].arm; abort_i = vecs[i].abort; sw_trig_i = vecs[i].sw;
            ext_trig_i = vecs[i].ext; trig_mask_i = vecs[i].mask;
            trig_delay_i = vecs[i].dly; cap_len_i = vecs[i].len; buf_tready_i = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d.cap", i), cap_en_o, vecs[i].cap);
            chk($sformatf("v%0d.int", i), int_trig_o, vecs[i].itr);
            chk($sformatf("v%0d.busy", i), busy_o, vecs[i].busy);
            chk($sformatf("v%0d.done", i), done_o, vecs[i].done);
            chk($sformatf("v%0d.ovf", i), overflow_o, vecs[i].ovf);
            chk($sformatf("v%0d.cnt", i), trig_count_o, vecs[i].cnt);
        end
        arm_i = 0; abort_i = 0; sw_trig_i = 0; ext_trig_i = 0; buf_tready_i = 4'hF;

        // ---- abort at beat 3 of a 100-beat capture ----
        pulse_arm(2'b01, 0, 99);
        tick();
        t_exp = ts_model;
        pulse_sw();
        tick();
        chk("ab.int", int_trig_o, 1);
        chk("ab.beat1", cap_en_o, 1);
        tick(); tick();
        chk("ab.beat3", cap_en_o, 1);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        tick();
        chk("ab.cap", cap_en_o, 0); chk("ab.busy", busy_o, 0); chk("ab.done", done_o, 0);
        chk("ab.cnt", trig_count_o, 4); chk("ab.time", trig_time_o, t_exp);
        arm_i = 1'b1; abort_i = 1'b1; tick(); arm_i = 1'b0; abort_i = 1'b0;
        tick(); tick();
        chk("armabort.busy", busy_o, 0);

        // ---- ignored triggers ----
        pulse_sw();
        run(3, p);
        chk("idle.trig", p, 0);
        pulse_arm(2'b10, 3, 2);
        tick();
        trig_mask_i = 2'b01;            // must not affect the latched mask
        pulse_sw();
        run(3, p);
        chk("masked.trig", p, 0); chk("masked.busy", busy_o, 1); chk("masked.cnt", trig_count_o, 4);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        tick();
        chk("masked.abort", busy_o, 0);
        arm_i = 1'b1; sw_trig_i = 1'b1; trig_mask_i = 2'b01; trig_delay_i = 3; cap_len_i = 2;
        tick();
        arm_i = 1'b0; sw_trig_i = 1'b0;
        run(4, p);
        chk("armcyc.trig", p, 0); chk("armcyc.busy", busy_o, 1);
        pulse_sw();
        tick();
        chk("d3.int", int_trig_o, 1); chk("d3.cnt", trig_count_o, 5);
        pulse_sw();                     // lands in DELAY
        run(8, p);
        chk("delay.trig", p, 0); chk("d3.done", done_o, 1);
        pulse_sw();                     // lands in DONE
        run(3, p);
        chk("done.trig", p, 0); chk("done.cnt", trig_count_o, 5);

        // ---- asynchronous reset during DELAY ----
        pulse_arm(2'b01, 50, 3);
        tick();
        pulse_sw();
        tick(); tick(); tick();
        chk("rd.busy", busy_o, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("rd.cap", cap_en_o, 0); chk("rd.busy0", busy_o, 0); chk("rd.done", done_o, 0);
        chk("rd.int", int_trig_o, 0); chk("rd.ovf", overflow_o, 0);
        chk("rd.cnt", trig_count_o, 0); chk("rd.time", trig_time_o, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        pulse_sw();
        run(4, p);
        chk("rd.notrig", p, 0); chk("rd.cnt0", trig_count_o, 0);
        pulse_arm(2'b01, 0, 0);
        tick();
        pulse_sw();
        tick();
        chk("rd.int1", int_trig_o, 1); chk("rd.cnt1", trig_count_o, 1);
        tick();
        chk("rd.done1", done_o, 1);

        // ---- trigger count wrap (4-bit counter) ----
        for (int i = 0; i < 14; i++) begin
            pulse_arm(2'b01, 0, 0);
            tick();
            pulse_sw();
            tick(); tick();
        end
        chk("wrap.15", trig_count_o, 15);
        pulse_arm(2'b01, 0, 0);
        tick();
        pulse_sw();
        tick();
        chk("wrap.0", trig_count_o, 0);
        chk("wrap.int", int_trig_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
